button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 196 +++++++++++++++++++
 tb/tb_button_debounce.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Five-button debouncer: per-bit 2-flop synchronizer, consecutive-sample debounce
// counter, priority-encoded one-hot press pulse. Auto-repeat is built only when BUTTON_REPEAT_EN is defined.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw_i,
    output logic [4:0] button_o,
    output logic [4:0] held_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("button_debounce: illegal parameter value");
    end

    logic [4:0]    sync1_r;
    logic [4:0]    sync2_r;
    logic [4:0]    held_r;
    logic [4:0]    held_prev_r;
    logic [4:0]    button_r;
    logic [CW-1:0] cnt_r      [5];
    logic [CW-1:0] cnt_next_s [5];
    logic [4:0]    held_next_s;
    logic [4:0]    rise_s;
    logic [4:0]    press_s;
    logic [4:0]    btn_next_s;

    // Fixed press priority: mid > up > down > left > right; losers are dropped.
    function automatic logic [4:0] priority_pick(input logic [4:0] ev);
        logic [4:0] pick;
        pick = 5'b00000;
        if (ev[4]) begin
            pick = 5'b10000;
        end else if (ev[0]) begin
            pick = 5'b00001;
        end else if (ev[1]) begin
            pick = 5'b00010;
        end else if (ev[2]) begin
            pick = 5'b00100;
        end else if (ev[3]) begin
            pick = 5'b01000;
        end else begin
            pick = 5'b00000;
        end
        return pick;
    endfunction

    // Two-flop synchronizer for the asynchronous raw buttons.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 5'b00000;
            sync2_r <= 5'b00000;
        end else begin
            sync1_r <= btn_raw_i;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: count consecutive differing samples, flip the level at the limit.
    always_comb begin
        held_next_s = held_r;
        for (int i = 0; i < 5; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (sync2_r[i] == held_r[i]) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LIMIT) begin
                cnt_next_s[i]  = CNT_ZERO;
                held_next_s[i] = sync2_r[i];
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce counters and the debounced level with its one-cycle-delayed copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            held_r      <= 5'b00000;
            held_prev_r <= 5'b00000;
        end else begin
            for (int i = 0; i < 5; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            held_r      <= held_next_s;
            held_prev_r <= held_r;
        end
    end

    assign rise_s  = held_r & ~held_prev_r;
    assign press_s = priority_pick(rise_s);

`ifdef BUTTON_REPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_PERIOD = 2'd2
    } rpt_state_t;

    localparam logic [15:0] DELAY_LIM  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] PERIOD_LIM = 16'(REPEAT_PERIOD - 1);

    rpt_state_t  rpt_state_r;
    rpt_state_t  rpt_state_s;
    logic [4:0]  rpt_target_r;
    logic [4:0]  rpt_target_s;
    logic [15:0] rpt_cnt_r;
    logic [15:0] rpt_cnt_s;
    logic [15:0] rpt_lim_s;
    logic        rpt_fire_s;

    // Repeat state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_state_r  <= RPT_IDLE;
            rpt_target_r <= 5'b00000;
            rpt_cnt_r    <= 16'd0;
        end else begin
            rpt_state_r  <= rpt_state_s;
            rpt_target_r <= rpt_target_s;
            rpt_cnt_r    <= rpt_cnt_s;
        end
    end

    // Repeat next-state: a fresh press always wins and retargets (mid cancels repeat).
    always_comb begin
        rpt_state_s  = rpt_state_r;
        rpt_target_s = rpt_target_r;
        rpt_cnt_s    = rpt_cnt_r;
        rpt_fire_s   = 1'b0;
        case (rpt_state_r)
            RPT_DELAY:  rpt_lim_s = DELAY_LIM;
            RPT_PERIOD: rpt_lim_s = PERIOD_LIM;
            default:    rpt_lim_s = 16'd0;
        endcase
        if (|press_s) begin
            rpt_cnt_s = 16'd0;
            if (press_s[4]) begin
                rpt_state_s  = RPT_IDLE;
                rpt_target_s = 5'b00000;
            end else begin
                rpt_state_s  = RPT_DELAY;
                rpt_target_s = press_s;
            end
        end else if (rpt_state_r == RPT_IDLE) begin
            rpt_state_s = RPT_IDLE;
        end else if (~|(held_r & rpt_target_r)) begin
            rpt_state_s  = RPT_IDLE;
            rpt_target_s = 5'b00000;
            rpt_cnt_s    = 16'd0;
        end else if (rpt_cnt_r == rpt_lim_s) begin
            rpt_fire_s  = 1'b1;
            rpt_state_s = RPT_PERIOD;
            rpt_cnt_s   = 16'd0;
        end else begin
            rpt_cnt_s = rpt_cnt_r + 16'd1;
        end
    end

    // Next pulse: new press first, otherwise a due repeat of the target.
    always_comb begin
        if (|press_s) begin
            btn_next_s = press_s;
        end else if (rpt_fire_s) begin
            btn_next_s = rpt_target_r;
        end else begin
            btn_next_s = 5'b00000;
        end
    end
`else
    assign btn_next_s = press_s;
`endif

    // Registered one-hot press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            button_r <= 5'b00000;
        end else begin
            button_r <= btn_next_s;
        end
    end

    assign button_o = button_r;
    assign held_o   = held_r;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with default parameters; repeat expectations follow BUTTON_REPEAT_EN.
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_raw_i;
    logic [4:0] button_o;
    logic [4:0] held_o;

    int checks;
    int failures;

    typedef struct {
        logic [4:0] press;
        logic [4:0] exp_btn;
        logic [4:0] exp_held;
    } vec_t;

    vec_t       vecs [10];
    int         got_e [$];
    logic [4:0] got_v [$];
    int         exp_e [$];

    button_debounce dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_i (btn_raw_i),
        .button_o  (button_o),
        .held_o    (held_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive raw low and expect no pulse while the levels fall.
    task automatic release_all(input int n);
        btn_raw_i = 5'b00000;
        for (int r = 0; r < n; r++) begin
            tick();
            check5("release_btn", button_o, 5'b00000);
        end
        check5("release_held", held_o, 5'b00000);
    endtask

    // Apply 'press' from edge 0, drop it at edge 'hold', record pulses over 'total' edges.
    task automatic record(input logic [4:0] press, input int hold, input int total);
        got_e.delete();
        got_v.delete();
        btn_raw_i = press;
        for (int e = 0; e < total; e++) begin
            if (e == hold) btn_raw_i = 5'b00000;
            tick();
            if (button_o != 5'b00000) begin
                got_e.push_back(e);
                got_v.push_back(button_o);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        btn_raw_i = 5'b00000;
        rst_n     = 1'b0;

        vecs[0] = '{5'b10000, 5'b10000, 5'b10000};
        vecs[1] = '{5'b00001, 5'b00001, 5'b00001};
        vecs[2] = '{5'b00010, 5'b00010, 5'b00010};
        vecs[3] = '{5'b00100, 5'b00100, 5'b00100};
        vecs[4] = '{5'b01000, 5'b01000, 5'b01000};
        vecs[5] = '{5'b10001, 5'b10000, 5'b10001};
        vecs[6] = '{5'b00110, 5'b00010, 5'b00110};
        vecs[7] = '{5'b01100, 5'b00100, 5'b01100};
        vecs[8] = '{5'b01001, 5'b00001, 5'b01001};
        vecs[9] = '{5'b11111, 5'b10000, 5'b11111};

        // Reset state.
        for (int r = 0; r < 3; r++) tick();
        check5("reset_btn", button_o, 5'b00000);
        check5("reset_held", held_o, 5'b00000);
        rst_n = 1'b1;
        release_all(5);

        // Vector table: pulse exactly after edge 23, level from edge 22.
        for (int v = 0; v < 10; v++) begin
            btn_raw_i = vecs[v].press;
            for (int e = 0; e < 40; e++) begin
                tick();
                check5("vec_btn", button_o, (e == 23) ? vecs[v].exp_btn : 5'b00000);
                if (e == 21) check5("vec_held_early", held_o, 5'b00000);
                if (e == 22 || e == 39) check5("vec_held", held_o, vecs[v].exp_held);
            end
            release_all(30);
        end

        // Bounce on down: 10 high / 5 low, four times.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 15; c++) begin
                btn_raw_i = (c < 10) ? 5'b00010 : 5'b00000;
                tick();
                check5("bounce_btn", button_o, 5'b00000);
                check5("bounce_held", held_o & 5'b00010, 5'b00000);
            end
        end
        release_all(30);

        // Up+mid together, release mid only: no late up pulse; then re-press up.
        record(5'b10001, 1000, 40);
        check_int("both_count", got_e.size(), 1);
        if (got_e.size() == 1) begin
            check_int("both_edge", got_e[0], 23);
            check5("both_val", got_v[0], 5'b10000);
        end
        btn_raw_i = 5'b00001;
        for (int e = 0; e < 40; e++) begin
            tick();
            check5("up_still_held", button_o, 5'b00000);
        end
        release_all(30);
        record(5'b00001, 1000, 40);
        check_int("repress_count", got_e.size(), 1);
        if (got_e.size() == 1) begin
            check_int("repress_edge", got_e[0], 23);
            check5("repress_val", got_v[0], 5'b00001);
        end
        release_all(30);

        // Right held through a 3-cycle reset: a fresh pulse 23 edges after release.
        btn_raw_i = 5'b01000;
        for (int e = 0; e < 100; e++) tick();
        rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            check5("inrst_btn", button_o, 5'b00000);
            check5("inrst_held", held_o, 5'b00000);
        end
        rst_n = 1'b1;
        record(5'b01000, 1000, 40);
        check_int("postrst_count", got_e.size(), 1);
        if (got_e.size() == 1) begin
            check_int("postrst_edge", got_e[0], 23);
            check5("postrst_val", got_v[0], 5'b01000);
        end
        release_all(30);

        // Left held 200 cycles: level falls at edge 222, so the last repeat lands at 213.
        exp_e.delete();
        exp_e.push_back(23);
`ifdef BUTTON_REPEAT_EN
        for (int t = 73; t <= 213; t += 10) exp_e.push_back(t);
`endif
        record(5'b00100, 200, 260);
        check_int("left_count", got_e.size(), exp_e.size());
        for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
            check_int("left_edge", got_e[i], exp_e[i]);
            check5("left_val", got_v[i], 5'b00100);
        end
        release_all(10);

        // Mid held 200 cycles never repeats.
        record(5'b10000, 200, 260);
        check_int("mid_count", got_e.size(), 1);
        if (got_e.size() == 1) begin
            check_int("mid_edge", got_e[0], 23);
            check5("mid_val", got_v[0], 5'b10000);
        end
        release_all(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
